axis_nchan_adder: RTL

- Parametrised N-channel complex AXI-Stream summing stage for the beamformer back end. Sits after the per-channel weight multipliers.
- Joins NUM_CH real/imag stream pairs beat-by-beat and sums them lane-wise (SAMPLES lanes per beat).
- Output format is selectable: wrap, saturate, scaled-round, or channel-0 bypass.
- Full valid/ready backpressure through a 2-stage pipeline, plus a runtime channel-enable mask and a tlast-mismatch error flag.

---
 rtl/axis_nchan_adder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/axis_nchan_adder.sv
// N-channel complex AXI-Stream lane-wise summer: joins NUM_CH real/imag streams,
// sums SAMPLES lanes per beat with a selectable output format, 2-stage pipeline.
module axis_nchan_adder #(
  parameter int NUM_CH       = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SAMPLES      = 8,
  parameter int DATA_WIDTH   = SAMPLE_WIDTH * SAMPLES,
  parameter int GUARD        = $clog2(NUM_CH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   sum_mode,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_real_tdata,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_imag_tdata,
  input  logic [NUM_CH-1:0]            s_axis_real_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_imag_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_real_tlast,
  input  logic [NUM_CH-1:0]            s_axis_imag_tlast,
  output logic [NUM_CH-1:0]            s_axis_real_tready,
  output logic [NUM_CH-1:0]            s_axis_imag_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_real_tdata,
  output logic [DATA_WIDTH-1:0]        m_axis_imag_tdata,
  output logic [DATA_WIDTH/8-1:0]      m_axis_real_tkeep,
  output logic [DATA_WIDTH/8-1:0]      m_axis_imag_tkeep,
  output logic                         m_axis_real_tvalid,
  output logic                         m_axis_imag_tvalid,
  output logic                         m_axis_real_tlast,
  output logic                         m_axis_imag_tlast,
  input  logic                         m_axis_real_tready,
  input  logic                         m_axis_imag_tready,
  output logic                         tlast_err
);
  localparam int STAGES = 2;
  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int SUM_W  = SAMPLE_WIDTH + GUARD + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [SUM_W-1:0] RND     = SUM_W'(2 ** (GUARD - 1));

  typedef struct packed {
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] re;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] im;
    logic [1:0]                        mode;
    logic                              last;
  } s1_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
    logic                  last;
  } s2_t;

  // Sum one lane across channels and format it; scale rounds half toward +inf.
  function automatic logic [SAMPLE_WIDTH-1:0] lane_fmt(
    input logic [1:0]                          mode,
    input logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0] terms
  );
    logic signed [SUM_W-1:0] sum;
    sum = '0;
    for (int k = 0; k < NUM_CH; k++)
      sum = sum + {{(SUM_W-SAMPLE_WIDTH){terms[k][SAMPLE_WIDTH-1]}}, terms[k]};
    case (mode)
      2'b00: lane_fmt = terms[0];
      2'b01: lane_fmt = sum[SAMPLE_WIDTH-1:0];
      2'b10: begin
        if (sum > SAT_MAX)      lane_fmt = SAT_MAX[SAMPLE_WIDTH-1:0];
        else if (sum < SAT_MIN) lane_fmt = SAT_MIN[SAMPLE_WIDTH-1:0];
        else                    lane_fmt = sum[SAMPLE_WIDTH-1:0];
      end
      default: lane_fmt = SAMPLE_WIDTH'((sum + RND) >>> GUARD);
    endcase
  endfunction

  logic [STAGES:1]     vld_pipe;
  logic [NUM_CH-1:0]   req;
  logic                accept, out_fire, p1_ready, p2_ready, mism;
  s1_t                 s1_d, s1_q;
  s2_t                 s2_d, s2_q;

  logic [SAMPLES-1:0][NUM_CH-1:0][SAMPLE_WIDTH-1:0] lane_re, lane_im;
  logic [SAMPLES-1:0][SAMPLE_WIDTH-1:0]             sum_re, sum_im;

  // Bypass only ever waits on channel 0.
  assign req      = (sum_mode == 2'b00) ? {{(NUM_CH-1){1'b0}}, 1'b1} : ch_enable;
  assign out_fire = vld_pipe[2] & m_axis_real_tready & m_axis_imag_tready;
  assign p2_ready = ~vld_pipe[2] | out_fire;
  assign p1_ready = ~vld_pipe[1] | p2_ready;
  assign accept   = (|req) & (&((s_axis_real_tvalid & s_axis_imag_tvalid) | ~req)) & p1_ready;

  assign s_axis_real_tready = {NUM_CH{accept}} & req;
  assign s_axis_imag_tready = {NUM_CH{accept}} & req;

  assign mism = (|((s_axis_real_tlast | s_axis_imag_tlast) & req)) &
                ~(&((s_axis_real_tlast & s_axis_imag_tlast) | ~req));

  always_comb begin
    s1_d      = '0;
    s1_d.mode = sum_mode;
    s1_d.last = |(s_axis_real_tlast & req);
    for (int k = 0; k < NUM_CH; k++) begin
      if (req[k]) begin
        s1_d.re[k] = s_axis_real_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        s1_d.im[k] = s_axis_imag_tdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    lane_re = '0;
    lane_im = '0;
    for (int l = 0; l < SAMPLES; l++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        lane_re[l][k] = s1_q.re[k][l*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        lane_im[l][k] = s1_q.im[k][l*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
  end

  for (genvar l = 0; l < SAMPLES; l++) begin : g_lane
    assign sum_re[l] = lane_fmt(s1_q.mode, lane_re[l]);
    assign sum_im[l] = lane_fmt(s1_q.mode, lane_im[l]);
  end

  assign s2_d.re   = sum_re;
  assign s2_d.im   = sum_im;
  assign s2_d.last = s1_q.last;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe  <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      tlast_err <= 1'b0;
    end else begin
      if (p1_ready) vld_pipe[1] <= accept;
      if (accept)   s1_q <= s1_d;
      if (accept & mism) tlast_err <= 1'b1;
      if (p2_ready) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
    end
  end

  assign m_axis_real_tdata  = s2_q.re;
  assign m_axis_imag_tdata  = s2_q.im;
  assign m_axis_real_tlast  = s2_q.last;
  assign m_axis_imag_tlast  = s2_q.last;
  assign m_axis_real_tvalid = vld_pipe[2];
  assign m_axis_imag_tvalid = vld_pipe[2];
  assign m_axis_real_tkeep  = {KEEP_W{vld_pipe[2]}};
  assign m_axis_imag_tkeep  = {KEEP_W{vld_pipe[2]}};

endmodule
